// File: rtl/rx_sample_reader.sv
// rx_sample_reader
// Consumer end of the RX DDC output interface. It runs entirely in the adc_clk domain.
// Each accepted rx_avail_A strobe is read as three 16-bit words through the rd_getI/rd_getQ
// mux selects and pushed into a first-word-fall-through word FIFO:
//   word0 = I[15:0], word1 = Q[15:0], word2 = {I[23:16], Q[23:16]}.
// A sample goes into the FIFO whole or not at all. FIFO space is reserved when the sample
// is accepted, so the three pushes that follow can never fail.
//
// Optional feature: define RX_READER_HDR_EN to emit a header word {4'hA, seq[11:0]} ahead of
// the first sample of every block of BLOCK_SAMPLES accepted samples.
//
// Ports
//   adc_clk     in   sole clock, posedge
//   reset_n     in   asynchronous active-low reset
//   rx_avail_A  in   1-cycle strobe, new I/Q sample on the rx_dout_A mux
//   rx_dout_A   in   16-bit DDC word selected by rd_getI/rd_getQ
//   rd_getI     out  select I[15:0]
//   rd_getQ     out  select Q[15:0]; both low selects {I[23:16],Q[23:16]}
//   rd_en       in   pop one word (ignored when empty)
//   rd_data     out  FIFO head word (0 when empty)
//   empty       out  FIFO empty
//   count       out  words held
//   ovfl        out  sticky, a sample was dropped
//   clr_ovfl    in   clears ovfl and drop_cnt (a drop in the same cycle wins)
//   drop_cnt    out  dropped-sample count, saturating
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for rx_avail_A, admission check against free space
// HDR     | pushing block header word (RX_READER_HDR_EN only)
// GET_I   | rd_getI high, pushing I[15:0]
// GET_Q   | rd_getQ high, pushing Q[15:0]
// GET_HI  | both selects low, pushing {I[23:16],Q[23:16]}

module rx_sample_reader #(
  parameter int unsigned DEPTH_LOG2    = 9,
  parameter int unsigned BLOCK_SAMPLES = 170
) (
  input  logic                  adc_clk,
  input  logic                  reset_n,
  input  logic                  rx_avail_A,
  input  logic [15:0]           rx_dout_A,
  output logic                  rd_getI,
  output logic                  rd_getQ,
  input  logic                  rd_en,
  output logic [15:0]           rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovfl,
  input  logic                  clr_ovfl,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] NEED_SMP = (DEPTH_LOG2 + 1)'(3);
  localparam logic [DEPTH_LOG2:0] NEED_HDR = (DEPTH_LOG2 + 1)'(4);
  localparam logic [DEPTH_LOG2:0] ONE_W    = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_I  = 3'd1,
    S_GET_Q  = 3'd2,
`ifdef RX_READER_HDR_EN
    S_HDR    = 3'd4,
`endif
    S_GET_HI = 3'd3
  } state_t;

  state_t state_q, state_d;
  logic   get_i_q, get_q_q;

  // FIFO storage and bookkeeping
  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2:0]   free_w;
  logic [DEPTH_LOG2:0]   need_w;

  logic        push;
  logic [15:0] push_data;
  logic        pop;
  logic        accept;
  logic        drop;
  logic        hdr_due;

  logic        ovfl_q, ovfl_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

`ifdef RX_READER_HDR_EN
  localparam int unsigned BLK_W = (BLOCK_SAMPLES > 1) ? $clog2(BLOCK_SAMPLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_SAMPLES - 1);

  logic [BLK_W-1:0] blk_q, blk_d;
  logic [11:0]      seq_q, seq_d;

  assign hdr_due = (blk_q == '0);

  // Only accepted samples advance the block position; drops leave it untouched.
  always_comb begin
    blk_d = blk_q;
    seq_d = seq_q;
    if (accept) begin
      blk_d = (blk_q == BLK_LAST) ? '0 : blk_q + 1'b1;
    end
    if (state_q == S_HDR) begin
      seq_d = seq_q + 12'd1;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_q <= '0;
      seq_q <= '0;
    end else begin
      blk_q <= blk_d;
      seq_q <= seq_d;
    end
  end
`else
  logic unused_blk_cfg;
  assign unused_blk_cfg = ^BLOCK_SAMPLES;
  assign hdr_due        = 1'b0;
`endif

  assign free_w = DEPTH_W - count_q;
  assign need_w = hdr_due ? NEED_HDR : NEED_SMP;
  assign pop    = rd_en && (count_q != '0);

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = 16'h0000;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_avail_A) begin
          if (free_w >= need_w) begin
            accept = 1'b1;
`ifdef RX_READER_HDR_EN
            state_d = hdr_due ? S_HDR : S_GET_I;
`else
            state_d = S_GET_I;
`endif
          end else begin
            drop = 1'b1;
          end
        end
      end
`ifdef RX_READER_HDR_EN
      S_HDR: begin
        push      = 1'b1;
        push_data = {4'hA, seq_q};
        drop      = rx_avail_A;
        state_d   = S_GET_I;
      end
`endif
      S_GET_I: begin
        push      = 1'b1;
        push_data = rx_dout_A;
        drop      = rx_avail_A;
        state_d   = S_GET_Q;
      end
      S_GET_Q: begin
        push      = 1'b1;
        push_data = rx_dout_A;
        drop      = rx_avail_A;
        state_d   = S_GET_HI;
      end
      S_GET_HI: begin
        push      = 1'b1;
        push_data = rx_dout_A;
        drop      = rx_avail_A;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_W;
      2'b01:   count_d = count_q - ONE_W;
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as clr_ovfl restarts the count at one.
  always_comb begin
    ovfl_d     = ovfl_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovfl_d = 1'b1;
      if (clr_ovfl) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (clr_ovfl) begin
      ovfl_d     = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      get_i_q    <= 1'b0;
      get_q_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovfl_q     <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      // Selects come from next state so they are stable for the whole capture cycle.
      get_i_q    <= (state_d == S_GET_I);
      get_q_q    <= (state_d == S_GET_Q);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovfl_q     <= ovfl_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; rd_data is masked while empty so stale words never show.
  always_ff @(posedge adc_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign rd_getI  = get_i_q;
  assign rd_getQ  = get_q_q;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rd_data  = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign ovfl     = ovfl_q;
  assign drop_cnt = drop_cnt_q;

endmodule
